// File: rtl/sysid_regfile_if.sv
// Avalon-MM slave bus bundle for the system-identification register file.
// The master drives the request side; the slave returns pipelined read data.
interface sysid_regfile_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regfile.sv
// System-identification register file: ID/timestamp words, scratch register,
// 64-bit uptime counter with coherent split reads, caps/control words.
module sysid_regfile #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          ADDR_W       = 3,
  parameter int          READ_LATENCY = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  sysid_regfile_if.slave bus
);

  if (ADDR_W < 3 || ADDR_W > 8) begin : g_bad_addr_w
    $error("sysid_regfile: ADDR_W=%0d outside 3..8", ADDR_W);
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("sysid_regfile: READ_LATENCY=%0d outside 1..3", READ_LATENCY);
  end

  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TS      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_CAPS    = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_CONTROL = ADDR_W'(6);

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic              wr_en;
  logic              clr_hit;
  logic              lock_hit;
  logic              scratch_hit;
  logic [63:0]       counter;
  logic [31:0]       hi_shadow;
  logic [31:0]       scratch;
  logic              scratch_lock;
  logic [31:0]       rd_mux;

  assign addr  = bus.address;
  assign rd_en = bus.read;
  // A read in the same cycle as a write wins; the write is dropped entirely.
  assign wr_en = bus.write & ~bus.read;

  assign clr_hit     = wr_en && (addr == A_CONTROL) && bus.byteenable[0] && bus.writedata[0];
  assign lock_hit    = wr_en && (addr == A_CONTROL) && bus.byteenable[0] && bus.writedata[1];
  assign scratch_hit = wr_en && (addr == A_SCRATCH) && !scratch_lock;

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_ID:      rd_mux = ID_VALUE;
      A_TS:      rd_mux = TIMESTAMP;
      A_SCRATCH: rd_mux = scratch;
      A_UP_LO:   rd_mux = counter[31:0];
      A_UP_HI:   rd_mux = hi_shadow;
      A_CAPS:    rd_mux = {15'd0, scratch_lock, 8'(ADDR_W), 8'(READ_LATENCY)};
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter      <= '0;
      hi_shadow    <= '0;
      scratch      <= '0;
      scratch_lock <= 1'b0;
    end else begin
      counter <= clr_hit ? 64'd0 : counter + 64'd1;
      // Reading the low word freezes the high word so the pair is coherent.
      if (rd_en && (addr == A_UP_LO)) hi_shadow <= counter[63:32];
      if (scratch_hit) scratch <= merge_lanes(scratch, bus.writedata, bus.byteenable);
      if (lock_hit) scratch_lock <= 1'b1;
    end
  end

  // ---- read pipeline: stage 0 captures the sample, last stage drives the bus
  logic [31:0]             rdata_p [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_p;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p <= '0;
      for (int k = 0; k < READ_LATENCY; k++) rdata_p[k] <= '0;
    end else begin
      vld_p[0] <= rd_en;
      if (rd_en) rdata_p[0] <= rd_mux;
      // Data only advances behind a valid, so the output holds its last value.
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_p[k] <= vld_p[k-1];
        if (vld_p[k-1]) rdata_p[k] <= rdata_p[k-1];
      end
    end
  end

  assign bus.readdata      = rdata_p[READ_LATENCY-1];
  assign bus.readdatavalid = vld_p[READ_LATENCY-1];

endmodule
